// File: rtl/mem_arbiter.sv
// Shared RAM port arbiter between the icache miss path and the dcache miss/writeback path.
// Dcache wins arbitration unless the icache has been starved for STARVE_LIMIT dcache transfers.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int WORD_W       = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    // icache side
    input  logic              iREN,
    input  logic [WORD_W-1:0] iaddr,
    output logic              iwait,
    output logic [WORD_W-1:0] iload,
    // dcache side
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [WORD_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    output logic              dwait,
    output logic [WORD_W-1:0] dload,
    // RAM side
    output logic              ramREN,
    output logic              ramWEN,
    output logic [WORD_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  logic [1:0]        ramstate
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT      = CNT_W'(STARVE_LIMIT);
    localparam logic [1:0]       RAM_ACCESS = 2'd2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] starve_q, starve_d;

    logic dreq;
    logic starved;
    logic access;

    assign dreq    = dREN | dWEN;
    assign starved = (starve_q == LIMIT) && iREN;
    assign access  = (ramstate == RAM_ACCESS);

    // Async reset makes the RAM enables drop the moment nRST falls, since outputs decode state_q.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        iwait    = 1'b1;
        dwait    = 1'b1;
        iload    = '0;
        dload    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;

        case (state_q)
            IDLE: begin
                if (dreq && !starved) begin
                    state_d = SERVE_D;
                end else if (iREN) begin
                    state_d  = SERVE_I;
                    starve_d = '0;
                end
            end

            SERVE_D: begin
                // A simultaneous read and write is treated as a write.
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                dload    = ramload;
                if (access) begin
                    dwait   = 1'b0;
                    state_d = IDLE;
                    if (iREN && (starve_q != LIMIT)) begin
                        starve_d = starve_q + CNT_W'(1);
                    end
                end else if (!dreq) begin
                    state_d = IDLE;
                end
            end

            SERVE_I: begin
                ramREN  = iREN;
                ramaddr = iaddr;
                iload   = ramload;
                if (access) begin
                    iwait   = 1'b0;
                    state_d = IDLE;
                end else if (!iREN) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, single read, dcache priority, starvation,
// stalled RAM, withdrawal and asynchronous reset mid-transfer.
module tb_mem_arbiter;

    localparam int WORD_W = 32;
    localparam logic [1:0] RS_FREE   = 2'd0;
    localparam logic [1:0] RS_BUSY   = 2'd1;
    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;
    localparam int ST_IDLE    = 0;
    localparam int ST_SERVE_I = 1;
    localparam int ST_SERVE_D = 2;

    logic              CLK;
    logic              nRST;
    logic              iREN;
    logic [WORD_W-1:0] iaddr;
    logic              iwait;
    logic [WORD_W-1:0] iload;
    logic              dREN;
    logic              dWEN;
    logic [WORD_W-1:0] daddr;
    logic [WORD_W-1:0] dstore;
    logic              dwait;
    logic [WORD_W-1:0] dload;
    logic              ramREN;
    logic              ramWEN;
    logic [WORD_W-1:0] ramaddr;
    logic [WORD_W-1:0] ramstore;
    logic [WORD_W-1:0] ramload;
    logic [1:0]        ramstate;

    int checks;
    int errors;

    mem_arbiter #(.STARVE_LIMIT(4), .WORD_W(WORD_W)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dwait    (dwait),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic test_reset();
        @(negedge CLK);
        ramload  = 32'hFFFF_0000;
        ramstate = RS_ACCESS;
        #1;
        checks++; if (iwait !== 1'b1) begin errors++; $display("FAIL reset_iwait got %b want 1", iwait); end
        checks++; if (dwait !== 1'b1) begin errors++; $display("FAIL reset_dwait got %b want 1", dwait); end
        checks++; if ({ramREN, ramWEN} !== 2'b00) begin errors++; $display("FAIL reset_ramen got %b want 00", {ramREN, ramWEN}); end
        checks++; if (ramaddr !== 32'h0) begin errors++; $display("FAIL reset_ramaddr got %h want 0", ramaddr); end
        checks++; if (ramstore !== 32'h0) begin errors++; $display("FAIL reset_ramstore got %h want 0", ramstore); end
        checks++; if ({iload, dload} !== 64'h0) begin errors++; $display("FAIL reset_loads got %h want 0", {iload, dload}); end
        @(negedge CLK);
        nRST = 1'b1;
        @(negedge CLK);
        #1;
        checks++; if (int'(dut.state_q) !== ST_IDLE) begin errors++; $display("FAIL idle_hold_state got %0d want %0d", int'(dut.state_q), ST_IDLE); end
        checks++; if (int'(dut.starve_q) !== 0) begin errors++; $display("FAIL idle_hold_counter got %0d want 0", int'(dut.starve_q)); end
        checks++; if ({iwait, dwait, ramREN, ramWEN} !== 4'b1100) begin errors++; $display("FAIL idle_hold_outputs got %b want 1100", {iwait, dwait, ramREN, ramWEN}); end
        ramstate = RS_FREE;
    endtask

    task automatic test_single_read();
        @(negedge CLK);
        iREN  = 1'b1;
        iaddr = 32'h40;
        ramstate = RS_BUSY;
        @(posedge CLK);
        @(negedge CLK);
        #1;
        checks++; if ({ramREN, ramaddr} !== {1'b1, 32'h40}) begin errors++; $display("FAIL rd_serve1 got %b/%h want 1/00000040", ramREN, ramaddr); end
        checks++; if (iwait !== 1'b1) begin errors++; $display("FAIL rd_serve1_iwait got %b want 1", iwait); end
        ramstate = RS_ACCESS;
        ramload  = 32'hDEAD_BEEF;
        #1;
        checks++; if ({iwait, dwait} !== 2'b01) begin errors++; $display("FAIL rd_access_waits got %b want 01", {iwait, dwait}); end
        checks++; if (iload !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_iload got %h want deadbeef", iload); end
        checks++; if (ramaddr !== 32'h40) begin errors++; $display("FAIL rd_ramaddr got %h want 00000040", ramaddr); end
        @(negedge CLK);
        iREN = 1'b0;
        ramstate = RS_FREE;
        #1;
        checks++; if (int'(dut.state_q) !== ST_IDLE) begin errors++; $display("FAIL rd_after_state got %0d want %0d", int'(dut.state_q), ST_IDLE); end
        checks++; if ({iwait, ramREN} !== 2'b10) begin errors++; $display("FAIL rd_after_out got %b want 10", {iwait, ramREN}); end
    endtask

    task automatic test_priority();
        @(negedge CLK);
        iREN   = 1'b1;
        iaddr  = 32'h44;
        dWEN   = 1'b1;
        daddr  = 32'h80;
        dstore = 32'h1234_5678;
        ramstate = RS_FREE;
        @(negedge CLK);
        #1;
        checks++; if (int'(dut.state_q) !== ST_SERVE_D) begin errors++; $display("FAIL pri_state got %0d want %0d", int'(dut.state_q), ST_SERVE_D); end
        checks++; if ({ramWEN, ramREN, ramaddr, ramstore} !== {2'b10, 32'h80, 32'h1234_5678}) begin
            errors++; $display("FAIL pri_ram got %b%b/%h/%h want 10/00000080/12345678", ramWEN, ramREN, ramaddr, ramstore);
        end
        ramstate = RS_ACCESS;
        #1;
        checks++; if ({iwait, dwait} !== 2'b10) begin errors++; $display("FAIL pri_waits got %b want 10", {iwait, dwait}); end
        @(negedge CLK);
        dWEN = 1'b0;
        ramstate = RS_FREE;
        #1;
        checks++; if ({iwait, dwait, ramREN, ramWEN} !== 4'b1100) begin errors++; $display("FAIL pri_idle got %b want 1100", {iwait, dwait, ramREN, ramWEN}); end
        checks++; if (int'(dut.starve_q) !== 1) begin errors++; $display("FAIL pri_counter got %0d want 1", int'(dut.starve_q)); end
        @(negedge CLK);
        ramstate = RS_ACCESS;
        ramload  = 32'h0000_CAFE;
        #1;
        checks++; if ({ramREN, ramaddr, iwait, iload} !== {1'b1, 32'h44, 1'b0, 32'h0000_CAFE}) begin
            errors++; $display("FAIL pri_then_i got %b/%h/%b/%h want 1/00000044/0/0000cafe", ramREN, ramaddr, iwait, iload);
        end
        checks++; if (int'(dut.starve_q) !== 0) begin errors++; $display("FAIL pri_counter_clr got %0d want 0", int'(dut.starve_q)); end
        @(negedge CLK);
        iREN = 1'b0;
        ramstate = RS_FREE;
    endtask

    task automatic test_starvation();
        @(negedge CLK);
        iREN  = 1'b1;
        iaddr = 32'h100;
        dREN  = 1'b1;
        daddr = 32'h200;
        ramstate = RS_ACCESS;
        ramload  = 32'h1111_2222;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            #1;
            checks++; if ({ramREN, ramaddr, dwait, iwait, dload} !== {1'b1, 32'h200, 1'b0, 1'b1, 32'h1111_2222}) begin
                errors++; $display("FAIL starve_d%0d got %b/%h/%b/%b/%h want 1/00000200/0/1/11112222", k, ramREN, ramaddr, dwait, iwait, dload);
            end
            @(negedge CLK);
            #1;
            checks++; if (int'(dut.starve_q) !== k + 1) begin errors++; $display("FAIL starve_cnt%0d got %0d want %0d", k, int'(dut.starve_q), k + 1); end
        end
        @(negedge CLK);
        #1;
        checks++; if (int'(dut.state_q) !== ST_SERVE_I) begin errors++; $display("FAIL starve_grant got %0d want %0d", int'(dut.state_q), ST_SERVE_I); end
        checks++; if ({ramREN, ramaddr, iwait, dwait} !== {1'b1, 32'h100, 2'b01}) begin
            errors++; $display("FAIL starve_i got %b/%h/%b%b want 1/00000100/01", ramREN, ramaddr, iwait, dwait);
        end
        checks++; if (int'(dut.starve_q) !== 0) begin errors++; $display("FAIL starve_cnt_clr got %0d want 0", int'(dut.starve_q)); end
        @(negedge CLK);
        iREN = 1'b0;
        dREN = 1'b0;
        ramstate = RS_FREE;
    endtask

    task automatic test_busy_error();
        logic [1:0] seq [5];
        seq = '{RS_BUSY, RS_BUSY, RS_BUSY, RS_ERROR, RS_ACCESS};
        @(negedge CLK);
        dWEN   = 1'b1;
        daddr  = 32'h300;
        dstore = 32'hA5A5_5A5A;
        ramstate = RS_BUSY;
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK);
            ramstate = seq[c];
            #1;
            checks++; if ({dwait, ramWEN, ramREN} !== {(c != 4), 2'b10}) begin
                errors++; $display("FAIL stall_c%0d got %b%b%b want %b10", c, dwait, ramWEN, ramREN, (c != 4));
            end
        end
        @(negedge CLK);
        dWEN = 1'b0;
        ramstate = RS_FREE;
        #1;
        checks++; if ({dwait, ramWEN, int'(dut.state_q) == ST_IDLE} !== 3'b101) begin
            errors++; $display("FAIL stall_after got %b%b state %0d want 10 state 0", dwait, ramWEN, int'(dut.state_q));
        end
    endtask

    task automatic test_withdraw();
        @(negedge CLK);
        dREN  = 1'b1;
        daddr = 32'h600;
        ramstate = RS_BUSY;
        @(negedge CLK);
        dREN = 1'b0;
        #1;
        checks++; if ({dwait, ramREN, ramWEN} !== 3'b100) begin errors++; $display("FAIL wd_serve got %b want 100", {dwait, ramREN, ramWEN}); end
        @(negedge CLK);
        #1;
        checks++; if (int'(dut.state_q) !== ST_IDLE) begin errors++; $display("FAIL wd_state got %0d want %0d", int'(dut.state_q), ST_IDLE); end
        checks++; if (dwait !== 1'b1) begin errors++; $display("FAIL wd_dwait got %b want 1", dwait); end
        ramstate = RS_FREE;
    endtask

    task automatic test_reset_mid();
        @(negedge CLK);
        iREN  = 1'b1;
        iaddr = 32'h500;
        ramstate = RS_BUSY;
        @(negedge CLK);
        #1;
        checks++; if (ramREN !== 1'b1) begin errors++; $display("FAIL rst_mid_pre got %b want 1", ramREN); end
        #1;
        nRST = 1'b0;
        #1;
        checks++; if ({ramREN, iwait} !== 2'b01) begin errors++; $display("FAIL rst_mid_async got %b want 01", {ramREN, iwait}); end
        @(posedge CLK);
        #1;
        checks++; if ({ramREN, iwait} !== 2'b01) begin errors++; $display("FAIL rst_mid_hold got %b want 01", {ramREN, iwait}); end
        @(negedge CLK);
        iREN = 1'b0;
        nRST = 1'b1;
        @(negedge CLK);
        #1;
        checks++; if (int'(dut.state_q) !== ST_IDLE) begin errors++; $display("FAIL rst_mid_state got %0d want %0d", int'(dut.state_q), ST_IDLE); end
        checks++; if (int'(dut.starve_q) !== 0) begin errors++; $display("FAIL rst_mid_cnt got %0d want 0", int'(dut.starve_q)); end
        checks++; if ({iwait, ramREN} !== 2'b10) begin errors++; $display("FAIL rst_mid_out got %b want 10", {iwait, ramREN}); end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        nRST     = 1'b0;
        iREN     = 1'b0;
        iaddr    = '0;
        dREN     = 1'b0;
        dWEN     = 1'b0;
        daddr    = '0;
        dstore   = '0;
        ramload  = '0;
        ramstate = RS_FREE;
        test_reset();
        test_single_read();
        test_priority();
        test_starvation();
        test_busy_error();
        test_withdraw();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
